stage2_alu_writeback: RTL and testbench

STAGE2_ALU_WRITEBACK -- requirements
Module: stage2_alu_writeback

---
 rtl/proc_pkg.sv | 57 +++++
 rtl/shift_unit.sv | 107 ++++++++++
 rtl/stage2_alu_writeback.sv | 113 +++++++++++
 tb/tb_stage2_alu_writeback.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor widths, opselect/operation encodings and single-bit shift step.
package proc_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned OPSEL_W = 3;
   localparam int unsigned SHAMT_W = 5;

   typedef enum logic [OPSEL_W-1:0] {
      SHIFT_REG   = 3'b000,
      ARITH_LOGIC = 3'b001,
      MEM_WRITE   = 3'b100,
      MEM_READ    = 3'b101
   } opselect_e;

   typedef enum logic [OP_W-1:0] {
      OP_ADD   = 3'b000,
      OP_SUB   = 3'b001,
      OP_AND   = 3'b010,
      OP_OR    = 3'b011,
      OP_XOR   = 3'b100,
      OP_SLT   = 3'b101,
      OP_PASSB = 3'b110,
      OP_NOTA  = 3'b111
   } arith_op_e;

   typedef enum logic [OP_W-1:0] {
      SH_SLL   = 3'b000,
      SH_SRL   = 3'b001,
      SH_SRA   = 3'b010,
      SH_ROL   = 3'b011,
      SH_PASS0 = 3'b100,
      SH_PASS1 = 3'b101,
      SH_PASS2 = 3'b110,
      SH_PASS3 = 3'b111
   } shift_op_e;

   typedef struct packed {
      logic              carry;
      logic [DATA_W-1:0] data;
   } shift_res_t;

   // One-bit shift; carry is the bit that leaves the word (or wraps for ROL).
   function automatic shift_res_t shift_step(input shift_op_e op, input logic [DATA_W-1:0] w);
      shift_res_t r;
      r = '{carry: 1'b0, data: w};
      case (op)
         SH_SLL:  r = '{carry: w[DATA_W-1], data: {w[DATA_W-2:0], 1'b0}};
         SH_SRL:  r = '{carry: w[0], data: {1'b0, w[DATA_W-1:1]}};
         SH_SRA:  r = '{carry: w[0], data: {w[DATA_W-1], w[DATA_W-1:1]}};
         SH_ROL:  r = '{carry: w[DATA_W-1], data: {w[DATA_W-2:0], w[DATA_W-1]}};
         default: r = '{carry: 1'b0, data: w};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/shift_unit.sv
// Shifter: iterative one bit per cycle by default; single-cycle barrel shifter
// when BARREL_SHIFT_EN is defined. Completion and result are presented combinationally.
module shift_unit
   import proc_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [OP_W-1:0]    op,
   input  logic [SHAMT_W-1:0] amount,
   input  logic [DATA_W-1:0]  data,
   output logic               busy,
   output logic               done_c,
   output shift_res_t         result_c
);

   shift_op_e op_in;
   assign op_in = shift_op_e'(op);

`ifdef BARREL_SHIFT_EN

   function automatic shift_res_t shift_barrel(input shift_op_e sop, input logic [DATA_W-1:0] d,
                                               input logic [SHAMT_W-1:0] n);
      logic [2*DATA_W-1:0] t;
      shift_res_t          r;
      r = '{carry: 1'b0, data: d};
      t = '0;
      if (n != '0) begin
         case (sop)
            SH_SLL: begin
               t = {{DATA_W{1'b0}}, d} << n;
               r = '{carry: t[DATA_W], data: t[DATA_W-1:0]};
            end
            SH_SRL: begin
               t = {d, {DATA_W{1'b0}}} >> n;
               r = '{carry: t[DATA_W-1], data: t[2*DATA_W-1:DATA_W]};
            end
            SH_SRA: begin
               t = (2*DATA_W)'($signed({d, {DATA_W{1'b0}}}) >>> n);
               r = '{carry: t[DATA_W-1], data: t[2*DATA_W-1:DATA_W]};
            end
            SH_ROL: begin
               t = {d, d} << n;
               r = '{carry: t[DATA_W], data: t[2*DATA_W-1:DATA_W]};
            end
            default: r = '{carry: 1'b0, data: d};
         endcase
      end
      return r;
   endfunction

   assign busy     = 1'b0;
   assign done_c   = start;
   assign result_c = shift_barrel(op_in, data, amount);

`else

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e             state;
   shift_op_e          sop;
   logic [DATA_W-1:0]  work;
   logic [SHAMT_W-1:0] count;
   shift_res_t         step_c;
   logic               immediate_c;

   // Zero amount and the pass-through opcodes finish in the accept cycle.
   assign immediate_c = (amount == '0) || op[OP_W-1];
   assign step_c      = shift_step(sop, work);
   assign busy        = (state == SHIFT);

   always_comb begin
      done_c   = 1'b0;
      result_c = '{carry: 1'b0, data: data};
      if (state == SHIFT) begin
         done_c   = (count == SHAMT_W'(1));
         result_c = step_c;
      end else if (start && immediate_c) begin
         done_c   = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         sop   <= SH_SLL;
         work  <= '0;
         count <= '0;
      end else if (state == IDLE) begin
         if (start && !immediate_c) begin
            state <= SHIFT;
            sop   <= op_in;
            work  <= data;
            count <= amount;
         end
      end else begin
         work  <= step_c.data;
         count <= count - SHAMT_W'(1);
         if (count == SHAMT_W'(1)) begin
            state <= IDLE;
         end
      end
   end

`endif

endmodule

// File: rtl/stage2_alu_writeback.sv
// Stage-2 ALU/writeback: arith datapath, flag generation and result registers.
// Shift implementation selected by BARREL_SHIFT_EN (undefined: iterative shifter).
module stage2_alu_writeback
   import proc_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic [DATA_W-1:0]  aluin1,
   input  logic [DATA_W-1:0]  aluin2,
   input  logic [OP_W-1:0]    operation_in,
   input  logic [OPSEL_W-1:0] opselect_in,
   input  logic [SHAMT_W-1:0] shift_number,
   input  logic               enable_arith,
   input  logic               enable_shift,
   output logic [DATA_W-1:0]  aluout,
   output logic               aluout_valid,
   output logic               carry_out,
   output logic               overflow_out,
   output logic               zero_out,
   output logic               busy,
   output logic               op_dropped
);

   logic              accept_arith_c;
   logic              accept_shift_c;
   logic              protocol_err_c;
   logic              shift_done_c;
   shift_res_t        shift_res_c;
   logic [DATA_W:0]   sum_c;
   logic [DATA_W:0]   diff_c;
   logic [DATA_W-1:0] arith_res_c;
   logic              arith_carry_c;
   logic              arith_ovf_c;

   // Arith wins a simultaneous issue; nothing is accepted while a shift runs.
   assign accept_arith_c = enable_arith && !busy;
   assign accept_shift_c = enable_shift && !enable_arith && !busy;
   assign protocol_err_c = (busy && (enable_arith || enable_shift)) || (enable_arith && enable_shift);

   shift_unit u_shift_unit (
      .clock    (clock),
      .reset    (reset),
      .start    (accept_shift_c),
      .op       (operation_in),
      .amount   (shift_number),
      .data     (aluin1),
      .busy     (busy),
      .done_c   (shift_done_c),
      .result_c (shift_res_c)
   );

   assign sum_c  = {1'b0, aluin1} + {1'b0, aluin2};
   assign diff_c = {1'b0, aluin1} - {1'b0, aluin2};

   always_comb begin
      arith_res_c   = aluin2;
      arith_carry_c = 1'b0;
      arith_ovf_c   = 1'b0;
      if (opselect_e'(opselect_in) != MEM_READ) begin
         case (arith_op_e'(operation_in))
            OP_ADD: begin
               arith_res_c   = sum_c[DATA_W-1:0];
               arith_carry_c = sum_c[DATA_W];
               arith_ovf_c   = (aluin1[DATA_W-1] == aluin2[DATA_W-1]) &&
                               (sum_c[DATA_W-1] != aluin1[DATA_W-1]);
            end
            OP_SUB: begin
               arith_res_c   = diff_c[DATA_W-1:0];
               arith_carry_c = diff_c[DATA_W];
               arith_ovf_c   = (aluin1[DATA_W-1] != aluin2[DATA_W-1]) &&
                               (diff_c[DATA_W-1] != aluin1[DATA_W-1]);
            end
            OP_AND:   arith_res_c = aluin1 & aluin2;
            OP_OR:    arith_res_c = aluin1 | aluin2;
            OP_XOR:   arith_res_c = aluin1 ^ aluin2;
            OP_SLT:   arith_res_c = DATA_W'($signed(aluin1) < $signed(aluin2));
            OP_PASSB: arith_res_c = aluin2;
            OP_NOTA:  arith_res_c = ~aluin1;
            default:  arith_res_c = aluin2;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         aluout       <= '0;
         aluout_valid <= 1'b0;
         carry_out    <= 1'b0;
         overflow_out <= 1'b0;
         zero_out     <= 1'b0;
         op_dropped   <= 1'b0;
      end else begin
         aluout_valid <= 1'b0;
         if (protocol_err_c) begin
            op_dropped <= 1'b1;
         end
         if (accept_arith_c) begin
            aluout       <= arith_res_c;
            carry_out    <= arith_carry_c;
            overflow_out <= arith_ovf_c;
            zero_out     <= (arith_res_c == '0);
            aluout_valid <= 1'b1;
         end else if (shift_done_c) begin
            aluout       <= shift_res_c.data;
            carry_out    <= shift_res_c.carry;
            overflow_out <= 1'b0;
            zero_out     <= (shift_res_c.data == '0);
            aluout_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stage2_alu_writeback.sv
// Directed self-checking bench for stage2_alu_writeback.
module tb_stage2_alu_writeback;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] aluin1, aluin2;
   logic [2:0]  operation_in, opselect_in;
   logic [4:0]  shift_number;
   logic        enable_arith, enable_shift;
   logic [31:0] aluout;
   logic        aluout_valid, carry_out, overflow_out, zero_out, busy, op_dropped;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        c;
      logic        v;
   } avec_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [4:0]  n;
      logic [31:0] r;
      logic        c;
   } svec_t;

   always #5 clock = ~clock;

   stage2_alu_writeback dut (
      .clock        (clock),
      .reset        (reset),
      .aluin1       (aluin1),
      .aluin2       (aluin2),
      .operation_in (operation_in),
      .opselect_in  (opselect_in),
      .shift_number (shift_number),
      .enable_arith (enable_arith),
      .enable_shift (enable_shift),
      .aluout       (aluout),
      .aluout_valid (aluout_valid),
      .carry_out    (carry_out),
      .overflow_out (overflow_out),
      .zero_out     (zero_out),
      .busy         (busy),
      .op_dropped   (op_dropped)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable_arith = 1'b0;
      enable_shift = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      aluin1 = 32'hFFFF_FFFF; aluin2 = 32'h1;
      operation_in = 3'b000; opselect_in = 3'b001; shift_number = 5'd3;
      enable_arith = 1'b0; enable_shift = 1'b0;
      step(); step();
      checks++;
      if ({aluout_valid, busy, op_dropped, carry_out, overflow_out, zero_out} !== 6'b0 || aluout !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: got out=%h v=%b busy=%b drop=%b c=%b o=%b z=%b expected all zero",
                  aluout, aluout_valid, busy, op_dropped, carry_out, overflow_out, zero_out);
      end
      reset = 1'b0;
   endtask

   task automatic test_arith();
      avec_t av[$];
      av.push_back('{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0});
      av.push_back('{3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1});
      av.push_back('{3'd1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b0});
      av.push_back('{3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1});
      av.push_back('{3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0});
      av.push_back('{3'd3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0});
      av.push_back('{3'd4, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1'b0});
      av.push_back('{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0});
      av.push_back('{3'd5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0});
      av.push_back('{3'd6, 32'h0000_0000, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0, 1'b0});
      av.push_back('{3'd7, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0});
      foreach (av[i]) begin
         opselect_in = 3'b001; operation_in = av[i].op;
         aluin1 = av[i].a; aluin2 = av[i].b; enable_arith = 1'b1;
         step();
         enable_arith = 1'b0; aluin1 = ~av[i].a; aluin2 = ~av[i].b;
         checks++;
         if ({aluout_valid, aluout, carry_out, overflow_out, zero_out} !==
             {1'b1, av[i].r, av[i].c, av[i].v, av[i].r == 32'h0}) begin
            errors++;
            $display("FAIL arith[%0d] op=%0d: got v=%b out=%h c=%b o=%b z=%b expected v=1 out=%h c=%b o=%b z=%b",
                     i, av[i].op, aluout_valid, aluout, carry_out, overflow_out, zero_out,
                     av[i].r, av[i].c, av[i].v, av[i].r == 32'h0);
         end
         step();
         checks++;
         if ({aluout_valid, aluout} !== {1'b0, av[i].r}) begin
            errors++;
            $display("FAIL arith_hold[%0d]: got v=%b out=%h expected v=0 out=%h", i, aluout_valid, aluout, av[i].r);
         end
      end
   endtask

   task automatic test_mem_read();
      opselect_in = 3'b101; operation_in = 3'b000;
      aluin1 = 32'hFFFF_FFFF; aluin2 = 32'hDEAD_BEEF; enable_arith = 1'b1;
      step();
      enable_arith = 1'b0;
      checks++;
      if ({aluout_valid, aluout, carry_out, overflow_out, zero_out} !== {1'b1, 32'hDEAD_BEEF, 3'b000}) begin
         errors++;
         $display("FAIL mem_read: got v=%b out=%h c=%b o=%b z=%b expected v=1 out=deadbeef c=0 o=0 z=0",
                  aluout_valid, aluout, carry_out, overflow_out, zero_out);
      end
      step();
   endtask

   task automatic test_back_to_back();
      opselect_in = 3'b001; operation_in = 3'b000;
      aluin1 = 32'd1; aluin2 = 32'd2; enable_arith = 1'b1;
      step();
      operation_in = 3'b001; aluin1 = 32'd10; aluin2 = 32'd3;
      checks++;
      if ({aluout_valid, aluout} !== {1'b1, 32'd3}) begin
         errors++;
         $display("FAIL b2b_first: got v=%b out=%h expected v=1 out=3", aluout_valid, aluout);
      end
      step();
      enable_arith = 1'b0;
      checks++;
      if ({aluout_valid, aluout, carry_out} !== {1'b1, 32'd7, 1'b0}) begin
         errors++;
         $display("FAIL b2b_second: got v=%b out=%h c=%b expected v=1 out=7 c=0", aluout_valid, aluout, carry_out);
      end
      step();
   endtask

   task automatic test_shift();
      svec_t sv[$];
      int lat, cyc, nbusy;
      sv.push_back('{3'd2, 32'h8000_0010, 5'd4,  32'hF800_0001, 1'b0});
      sv.push_back('{3'd0, 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1});
      sv.push_back('{3'd1, 32'h0000_0003, 5'd1,  32'h0000_0001, 1'b1});
      sv.push_back('{3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0});
      sv.push_back('{3'd3, 32'h9000_0000, 5'd4,  32'h0000_0009, 1'b1});
      sv.push_back('{3'd2, 32'h7FFF_FFFF, 5'd8,  32'h007F_FFFF, 1'b1});
      sv.push_back('{3'd4, 32'h1234_5678, 5'd7,  32'h1234_5678, 1'b0});
      sv.push_back('{3'd0, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1'b0});
      sv.push_back('{3'd0, 32'h0000_0001, 5'd1,  32'h0000_0002, 1'b0});
      foreach (sv[i]) begin
         // Leave overflow set beforehand so the shift must clear it.
         opselect_in = 3'b001; operation_in = 3'b000;
         aluin1 = 32'h7FFF_FFFF; aluin2 = 32'h1; enable_arith = 1'b1;
         step();
         enable_arith = 1'b0;
         operation_in = sv[i].op; aluin1 = sv[i].a; shift_number = sv[i].n; enable_shift = 1'b1;
`ifdef BARREL_SHIFT_EN
         lat = 1;
`else
         lat = (sv[i].n == 5'd0 || sv[i].op[2]) ? 1 : int'(sv[i].n) + 1;
`endif
         step();
         enable_shift = 1'b0; aluin1 = 32'h0; shift_number = 5'd0;
         cyc = 1; nbusy = 0;
         while (aluout_valid !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) nbusy++;
            step();
            cyc++;
         end
         checks++;
         if (cyc != lat || nbusy != lat - 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL shift_timing[%0d]: got latency=%0d busy_cycles=%0d busy=%b expected latency=%0d busy_cycles=%0d busy=0",
                     i, cyc, nbusy, busy, lat, lat - 1);
         end
         checks++;
         if ({aluout_valid, aluout, carry_out, overflow_out, zero_out} !==
             {1'b1, sv[i].r, sv[i].c, 1'b0, sv[i].r == 32'h0}) begin
            errors++;
            $display("FAIL shift_result[%0d] op=%0d n=%0d: got v=%b out=%h c=%b o=%b z=%b expected v=1 out=%h c=%b o=0 z=%b",
                     i, sv[i].op, sv[i].n, aluout_valid, aluout, carry_out, overflow_out, zero_out,
                     sv[i].r, sv[i].c, sv[i].r == 32'h0);
         end
         step();
         checks++;
         if (aluout_valid !== 1'b0) begin
            errors++;
            $display("FAIL shift_pulse[%0d]: got valid=%b expected 0", i, aluout_valid);
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      opselect_in = 3'b001; operation_in = 3'b000; aluin1 = 32'd2; aluin2 = 32'd3; shift_number = 5'd5;
      enable_arith = 1'b1; enable_shift = 1'b1;
      step();
      enable_arith = 1'b0; enable_shift = 1'b0;
      checks++;
      if ({aluout_valid, aluout, busy, op_dropped} !== {1'b1, 32'd5, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL simultaneous: got v=%b out=%h busy=%b drop=%b expected v=1 out=5 busy=0 drop=1",
                  aluout_valid, aluout, busy, op_dropped);
      end
      step();
      checks++;
      if ({aluout_valid, busy, op_dropped, aluout} !== {1'b0, 1'b0, 1'b1, 32'd5}) begin
         errors++;
         $display("FAIL simultaneous_after: got v=%b busy=%b drop=%b out=%h expected v=0 busy=0 drop=1 out=5",
                  aluout_valid, busy, op_dropped, aluout);
      end
   endtask

`ifndef BARREL_SHIFT_EN
   task automatic test_drop_busy();
      int cyc;
      do_reset();
      opselect_in = 3'b000; operation_in = 3'b000; aluin1 = 32'h1; shift_number = 5'd31; enable_shift = 1'b1;
      step();
      enable_shift = 1'b0;
      checks++;
      if ({busy, op_dropped} !== 2'b10) begin
         errors++;
         $display("FAIL drop_start: got busy=%b drop=%b expected busy=1 drop=0", busy, op_dropped);
      end
      opselect_in = 3'b001; aluin1 = 32'd5; aluin2 = 32'd6; enable_arith = 1'b1;
      step();
      enable_arith = 1'b0;
      checks++;
      if ({op_dropped, aluout_valid, aluout} !== {1'b1, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL drop_flag: got drop=%b v=%b out=%h expected drop=1 v=0 out=0", op_dropped, aluout_valid, aluout);
      end
      cyc = 2;
      while (aluout_valid !== 1'b1 && cyc < 40) begin
         step();
         cyc++;
      end
      checks++;
      if ({cyc, aluout, carry_out, op_dropped} !== {32'd32, 32'h8000_0000, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL drop_result: got latency=%0d out=%h c=%b drop=%b expected latency=32 out=80000000 c=0 drop=1",
                  cyc, aluout, carry_out, op_dropped);
      end
      step();
   endtask

   task automatic test_reset_mid_shift();
      int pulses;
      do_reset();
      opselect_in = 3'b001; operation_in = 3'b000; aluin1 = 32'd1; aluin2 = 32'd1; enable_arith = 1'b1;
      step();
      enable_arith = 1'b0;
      checks++;
      if (aluout !== 32'd2) begin
         errors++;
         $display("FAIL midreset_pre: got out=%h expected 2", aluout);
      end
      operation_in = 3'b000; aluin1 = 32'h1; shift_number = 5'd10; enable_shift = 1'b1;
      step();
      enable_shift = 1'b0;
      step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({busy, aluout_valid, op_dropped, carry_out, aluout} !== {4'b0000, 32'h0}) begin
         errors++;
         $display("FAIL midreset_state: got busy=%b v=%b drop=%b c=%b out=%h expected all zero",
                  busy, aluout_valid, op_dropped, carry_out, aluout);
      end
      pulses = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (aluout_valid === 1'b1 || busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL midreset_aborted: got %0d valid/busy cycles expected 0", pulses);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_arith();
      test_mem_read();
      test_back_to_back();
      test_shift();
      test_simultaneous();
`ifndef BARREL_SHIFT_EN
      test_drop_busy();
      test_reset_mid_shift();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
